// File: rtl/if_else_parser_2.sv
// Streaming parser/evaluator for one statement of the form
// "if (a op b) begin v <= n; end else begin v <= n; end", one ASCII char per valid cycle.
module if_else_parser_2 (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [31:0] x,
   input  logic [6:0]         ascii_char,
   input  logic               char_valid,
   output logic signed [31:0] p,
   output logic [6:0]         assignment_var,
   output logic               parsing_done,
   output logic               error_flag,
   output logic [3:0]         error_code
);
   localparam logic [3:0] NO_ERROR          = 4'd0;
   localparam logic [3:0] INVALID_KEYWORD   = 4'd1;
   localparam logic [3:0] VAR_MISMATCH      = 4'd2;
   localparam logic [3:0] INVALID_CHAR      = 4'd3;
   localparam logic [3:0] MISSING_SEMICOLON = 4'd4;
   localparam logic [3:0] MISSING_OPERATOR  = 4'd5;
   localparam logic [3:0] SYNTAX_ERROR      = 4'd6;

   // Keywords are left-aligned so character i is always the top byte after a shift.
   localparam logic [39:0] KW_IF    = {"if", 24'd0};
   localparam logic [39:0] KW_BEGIN = "begin";
   localparam logic [39:0] KW_END   = {"end", 16'd0};
   localparam logic [39:0] KW_ELSE  = {"else", 8'd0};

   typedef enum logic [3:0] {
      IF_KW, COND_OPEN, OPND_A, RELOP, OPND_B, COND_CLOSE, BEGIN_KW, VAR,
      ASSIGN_OP, NUM, SEMI, END_KW, ELSE_KW, DONE, ERROR
   } state_t;

   typedef enum logic [2:0] {OP_LT, OP_LE, OP_GT, OP_GE, OP_EQ, OP_NE} relop_t;

   state_t             state_q, state_d, eff_state;
   relop_t             relop_q, relop_d;
   logic [2:0]         idx_q, idx_d, eff_idx, kw_last;
   logic [1:0]         pdepth_q, pdepth_d;
   logic               branch_q, branch_d, neg_q, neg_d, dig_q, dig_d;
   logic               a_is_x_q, a_is_x_d, b_is_x_q, b_is_x_d, cond_q, cond_d;
   logic [31:0]        acc_q, acc_d;
   logic signed [31:0] a_val_q, a_val_d, b_val_q, b_val_d;
   logic signed [31:0] val_if_q, val_if_d, val_else_q, val_else_d, p_q, p_d;
   logic signed [31:0] lit_val, cmp_a, cmp_b;
   logic [6:0]         var_cur_q, var_cur_d, var_if_q, var_if_d, avar_q, avar_d;
   logic               done_q, done_d, err_q, err_d;
   logic [3:0]         code_q, code_d, err_val;
   logic [7:0]         ch8, kw_byte;
   logic [39:0]        kw_sel;
   logic               is_ws, is_digit, is_alpha, is_lower, is_bad, is_relop;
   logic               consume, err_en, finish_assign, cond_now;

   assign ch8      = {1'b0, ascii_char};
   assign is_ws    = (ch8 == " ") || (ch8 == 8'h09) || (ch8 == 8'h0D) || (ch8 == 8'h0A);
   assign is_digit = (ch8 >= "0") && (ch8 <= "9");
   assign is_lower = (ch8 >= "a") && (ch8 <= "z");
   assign is_alpha = is_lower || ((ch8 >= "A") && (ch8 <= "Z"));
   assign is_bad   = !is_ws && ((ch8 < 8'h20) || (ch8 == 8'h7F));
   assign is_relop = (ch8 == "<") || (ch8 == ">") || (ch8 == "=") || (ch8 == "!");
   assign consume  = char_valid && (state_q != DONE) && (state_q != ERROR);
   assign lit_val  = neg_q ? (32'd0 - acc_q) : acc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IF_KW;      relop_q <= OP_LT;     idx_q <= '0;      pdepth_q <= '0;
         branch_q <= 1'b0;      neg_q <= 1'b0;        dig_q <= 1'b0;    cond_q <= 1'b0;
         a_is_x_q <= 1'b0;      b_is_x_q <= 1'b0;     acc_q <= '0;      a_val_q <= '0;
         b_val_q <= '0;         val_if_q <= '0;       val_else_q <= '0; p_q <= '0;
         var_cur_q <= '0;       var_if_q <= '0;       avar_q <= '0;
         done_q <= 1'b0;        err_q <= 1'b0;        code_q <= NO_ERROR;
      end else begin
         state_q <= state_d;    relop_q <= relop_d;   idx_q <= idx_d;   pdepth_q <= pdepth_d;
         branch_q <= branch_d;  neg_q <= neg_d;       dig_q <= dig_d;   cond_q <= cond_d;
         a_is_x_q <= a_is_x_d;  b_is_x_q <= b_is_x_d; acc_q <= acc_d;   a_val_q <= a_val_d;
         b_val_q <= b_val_d;    val_if_q <= val_if_d; val_else_q <= val_else_d; p_q <= p_d;
         var_cur_q <= var_cur_d; var_if_q <= var_if_d; avar_q <= avar_d;
         done_q <= done_d;      err_q <= err_d;       code_q <= code_d;
      end
   end

   always_comb begin
      state_d = state_q;     relop_d = relop_q;     idx_d = idx_q;       pdepth_d = pdepth_q;
      branch_d = branch_q;   neg_d = neg_q;         dig_d = dig_q;       cond_d = cond_q;
      a_is_x_d = a_is_x_q;   b_is_x_d = b_is_x_q;   acc_d = acc_q;       a_val_d = a_val_q;
      b_val_d = b_val_q;     val_if_d = val_if_q;   val_else_d = val_else_q; p_d = p_q;
      var_cur_d = var_cur_q; var_if_d = var_if_q;   avar_d = avar_q;
      done_d = done_q;       err_d = err_q;         code_d = code_q;
      err_en = 1'b0;         err_val = NO_ERROR;    finish_assign = 1'b0;
      eff_state = state_q;   eff_idx = idx_q;       kw_sel = KW_IF;      kw_last = 3'd1;

      // A token that ends without a delimiter hands its terminating char to the next state.
      if (consume) begin
         if ((state_q == RELOP) && (ch8 != "=") && ((relop_q == OP_LT) || (relop_q == OP_GT))) begin
            eff_state = OPND_B;
            eff_idx   = 3'd0;
         end else if (((state_q == OPND_A) || (state_q == OPND_B)) && (idx_q == 3'd1) && !is_digit) begin
            eff_idx = 3'd2;
            acc_d   = '0;
            neg_d   = 1'b0;
            if (state_q == OPND_A) begin
               a_val_d = lit_val;
            end else begin
               b_val_d = lit_val;
               if (pdepth_q == 2'd0) begin
                  eff_state = COND_CLOSE;
                  eff_idx   = 3'd0;
               end
            end
         end
         state_d = eff_state;
         idx_d   = eff_idx;
      end

      cmp_a    = a_is_x_q ? x : a_val_q;
      cmp_b    = b_is_x_d ? x : b_val_d;
      cond_now = 1'b0;
      case (relop_q)
         OP_LT:   cond_now = cmp_a <  cmp_b;
         OP_LE:   cond_now = cmp_a <= cmp_b;
         OP_GT:   cond_now = cmp_a >  cmp_b;
         OP_GE:   cond_now = cmp_a >= cmp_b;
         OP_EQ:   cond_now = cmp_a == cmp_b;
         default: cond_now = cmp_a != cmp_b;
      endcase

      case (state_q)
         BEGIN_KW: begin kw_sel = KW_BEGIN; kw_last = 3'd4; end
         END_KW:   begin kw_sel = KW_END;   kw_last = 3'd2; end
         ELSE_KW:  begin kw_sel = KW_ELSE;  kw_last = 3'd3; end
         default:  begin kw_sel = KW_IF;    kw_last = 3'd1; end
      endcase
      kw_byte = kw_sel[39 - {idx_q, 3'b000} -: 8];

      if (consume && is_bad) begin
         err_en  = 1'b1;
         err_val = INVALID_CHAR;
      end else if (consume) begin
         case (eff_state)
            IF_KW, BEGIN_KW, END_KW, ELSE_KW: begin
               if (is_ws && (idx_q == 3'd0)) begin
                  idx_d = 3'd0;
               end else if (ch8 == kw_byte) begin
                  idx_d = idx_q + 3'd1;
                  if (idx_q == kw_last) begin
                     idx_d = 3'd0;
                     case (state_q)
                        IF_KW:    state_d = COND_OPEN;
                        BEGIN_KW: state_d = VAR;
                        ELSE_KW:  begin state_d = BEGIN_KW; branch_d = 1'b1; end
                        default: begin
                           if (!branch_q) begin
                              state_d = ELSE_KW;
                           end else begin
                              state_d = DONE;
                              done_d  = 1'b1;
                              p_d     = cond_q ? val_if_q : val_else_q;
                              avar_d  = cond_q ? var_if_q : var_cur_q;
                           end
                        end
                     endcase
                  end
               end else begin
                  err_en  = 1'b1;
                  err_val = is_alpha ? INVALID_KEYWORD : SYNTAX_ERROR;
               end
            end
            COND_OPEN: begin
               if (ch8 == "(") begin
                  state_d = OPND_A; idx_d = 3'd0; pdepth_d = 2'd0;
                  acc_d = '0; neg_d = 1'b0;
               end else if (!is_ws) begin
                  err_en  = 1'b1;
                  err_val = is_alpha ? INVALID_KEYWORD : SYNTAX_ERROR;
               end
            end
            OPND_A, OPND_B: begin
               if (eff_idx == 3'd0) begin
                  if (is_ws && !neg_q) begin
                     idx_d = 3'd0;
                  end else if ((ch8 == "(") && !neg_q && (pdepth_q != 2'd3)) begin
                     pdepth_d = pdepth_q + 2'd1;
                  end else if ((ch8 == "-") && !neg_q) begin
                     neg_d = 1'b1;
                  end else if (is_digit) begin
                     acc_d = {28'd0, ascii_char[3:0]};
                     idx_d = 3'd1;
                     if (eff_state == OPND_A) a_is_x_d = 1'b0; else b_is_x_d = 1'b0;
                  end else if ((ch8 == "x") && !neg_q) begin
                     idx_d = 3'd2;
                     if (eff_state == OPND_A) begin
                        a_is_x_d = 1'b1;
                     end else begin
                        b_is_x_d = 1'b1;
                        if (pdepth_q == 2'd0) begin state_d = COND_CLOSE; idx_d = 3'd0; end
                     end
                  end else begin
                     err_en = 1'b1; err_val = SYNTAX_ERROR;
                  end
               end else if (eff_idx == 3'd1) begin
                  acc_d = acc_q * 32'd10 + {28'd0, ascii_char[3:0]};
               end else if (is_ws) begin
                  idx_d = 3'd2;
               end else if (ch8 == ")") begin
                  if (pdepth_q != 2'd0) begin
                     pdepth_d = pdepth_q - 2'd1;
                     if ((eff_state == OPND_B) && (pdepth_q == 2'd1)) begin
                        state_d = COND_CLOSE; idx_d = 3'd0;
                     end
                  end else begin
                     err_en = 1'b1; err_val = MISSING_OPERATOR;
                  end
               end else if ((eff_state == OPND_A) && is_relop && (pdepth_q == 2'd0)) begin
                  state_d = RELOP;
                  relop_d = (ch8 == "<") ? OP_LT : (ch8 == ">") ? OP_GT : (ch8 == "=") ? OP_EQ : OP_NE;
               end else begin
                  err_en  = 1'b1;
                  err_val = ((eff_state == OPND_A) && !is_relop) ? MISSING_OPERATOR : SYNTAX_ERROR;
               end
            end
            RELOP: begin
               if (ch8 == "=") begin
                  state_d  = OPND_B; idx_d = 3'd0; pdepth_d = 2'd0;
                  relop_d  = (relop_q == OP_LT) ? OP_LE : (relop_q == OP_GT) ? OP_GE : relop_q;
               end else begin
                  err_en = 1'b1; err_val = MISSING_OPERATOR;
               end
            end
            COND_CLOSE: begin
               if (ch8 == ")") begin
                  cond_d = cond_now; state_d = BEGIN_KW; idx_d = 3'd0; branch_d = 1'b0;
               end else if (!is_ws) begin
                  err_en = 1'b1; err_val = SYNTAX_ERROR;
               end
            end
            VAR: begin
               if (is_lower) begin
                  var_cur_d = ascii_char; state_d = ASSIGN_OP; idx_d = 3'd0;
               end else if (!is_ws) begin
                  err_en = 1'b1; err_val = SYNTAX_ERROR;
               end
            end
            ASSIGN_OP: begin
               if ((idx_q == 3'd0) && is_ws) begin
                  idx_d = 3'd0;
               end else if ((idx_q == 3'd0) && (ch8 == "<")) begin
                  idx_d = 3'd1;
               end else if ((idx_q == 3'd1) && (ch8 == "=")) begin
                  state_d = NUM; idx_d = 3'd0; acc_d = '0; neg_d = 1'b0; dig_d = 1'b0;
               end else begin
                  err_en  = 1'b1;
                  err_val = ((idx_q == 3'd0) && is_alpha) ? SYNTAX_ERROR : MISSING_OPERATOR;
               end
            end
            NUM: begin
               if (is_digit) begin
                  acc_d = acc_q * 32'd10 + {28'd0, ascii_char[3:0]};
                  dig_d = 1'b1;
               end else if (dig_q && (ch8 == ";")) begin
                  finish_assign = 1'b1;
               end else if (dig_q && is_ws) begin
                  state_d = SEMI;
               end else if (is_ws && !neg_q) begin
                  idx_d = 3'd0;
               end else if ((ch8 == "-") && !neg_q && !dig_q) begin
                  neg_d = 1'b1;
               end else begin
                  err_en  = 1'b1;
                  err_val = dig_q ? MISSING_SEMICOLON : SYNTAX_ERROR;
               end
            end
            SEMI: begin
               if (ch8 == ";") begin
                  finish_assign = 1'b1;
               end else if (!is_ws) begin
                  err_en = 1'b1; err_val = MISSING_SEMICOLON;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end

      if (finish_assign) begin
         if (!branch_q) begin
            val_if_d = lit_val;
            var_if_d = var_cur_q;
         end else begin
            val_else_d = lit_val;
            if (var_cur_q != var_if_q) begin
               err_en = 1'b1; err_val = VAR_MISMATCH;
            end
         end
         state_d = END_KW; idx_d = 3'd0; acc_d = '0; neg_d = 1'b0; dig_d = 1'b0;
      end

      if (err_en) begin
         state_d = ERROR;
         err_d   = 1'b1;
         code_d  = err_val;
      end
   end

   assign p              = p_q;
   assign assignment_var = avar_q;
   assign parsing_done   = done_q;
   assign error_flag     = err_q;
   assign error_code     = code_q;
endmodule

// File: tb/tb_if_else_parser_2.sv
// Directed self-checking bench for if_else_parser_2: character streams with hand-computed results.
module tb_if_else_parser_2;
   logic               clk = 1'b0;
   logic               rst;
   logic signed [31:0] x;
   logic [6:0]         ascii_char;
   logic               char_valid;
   logic signed [31:0] p;
   logic [6:0]         assignment_var;
   logic               parsing_done;
   logic               error_flag;
   logic [3:0]         error_code;
   int                 total = 0;
   int                 bad = 0;

   localparam string S_MAIN = "if ( ( x ) <= ( 5 ) ) begin a <= 73 ; endelse begin a <= 37 ; end";

   if_else_parser_2 dut (
      .clk(clk), .rst(rst), .x(x), .ascii_char(ascii_char), .char_valid(char_valid),
      .p(p), .assignment_var(assignment_var), .parsing_done(parsing_done),
      .error_flag(error_flag), .error_code(error_code)
   );

   always #5 clk = ~clk;

   // Count one comparison and report it if observed differs from expected.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Present one character for exactly one rising edge, optionally followed by an idle cycle
   // carrying a character that would be an error if it were wrongly consumed.
   task automatic feedChar(input logic [6:0] c, input bit gap);
      @(negedge clk);
      ascii_char = c;
      char_valid = 1'b1;
      if (gap) begin
         @(negedge clk);
         char_valid = 1'b0;
         ascii_char = 7'h01;
      end
   endtask

   // Stream a whole string; returns on the falling edge after the last character was consumed.
   task automatic applyStimulus(input string s, input bit gap);
      byte b;
      for (int i = 0; i < s.len(); i++) begin
         b = s[i];
         feedChar(b[6:0], gap);
      end
      @(negedge clk);
      char_valid = 1'b0;
      ascii_char = 7'h01;
   endtask

   // Pulse reset across one rising edge, releasing it on a falling edge.
   task automatic applyReset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Check the full output set after a statement that should have completed cleanly.
   task automatic checkDone(input string tag, input logic [31:0] exp_p, input logic [6:0] exp_var);
      checkOutput({tag, "_done"}, 32'(parsing_done), 32'd1);
      checkOutput({tag, "_p"}, p, exp_p);
      checkOutput({tag, "_var"}, 32'(assignment_var), 32'(exp_var));
      checkOutput({tag, "_err"}, 32'(error_flag), 32'd0);
   endtask

   // Check the outputs after a stream that should have stopped with the given code.
   task automatic checkErr(input string tag, input logic [3:0] exp_code);
      checkOutput({tag, "_flag"}, 32'(error_flag), 32'd1);
      checkOutput({tag, "_code"}, 32'(error_code), 32'(exp_code));
      checkOutput({tag, "_done"}, 32'(parsing_done), 32'd0);
      checkOutput({tag, "_p"}, p, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      x = '0;
      ascii_char = 7'h00;
      char_valid = 1'b0;
      #12;
      checkOutput("rst_p", p, 32'd0);
      checkOutput("rst_var", 32'(assignment_var), 32'd0);
      checkOutput("rst_done", 32'(parsing_done), 32'd0);
      checkOutput("rst_err", 32'(error_flag), 32'd0);
      checkOutput("rst_code", 32'(error_code), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // 2 <= 5 selects the if branch.
      x = 32'sd2;
      applyStimulus(S_MAIN, 1'b0);
      checkDone("main_x2", 32'd73, 7'h61);
      checkOutput("main_x2_code", 32'(error_code), 32'd0);

      // Characters after completion are ignored.
      applyStimulus("if ( x", 1'b0);
      checkDone("ignore", 32'd73, 7'h61);

      // Asynchronous reset clears outputs before any clock edge.
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_p", p, 32'd0);
      checkOutput("async_done", 32'(parsing_done), 32'd0);
      checkOutput("async_var", 32'(assignment_var), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // 7 <= 5 is false: else branch, with idle cycles between characters.
      x = 32'sd7;
      applyStimulus(S_MAIN, 1'b1);
      checkDone("main_x7_gap", 32'd37, 7'h61);

      // Else branch assigns a different variable.
      applyReset();
      x = 32'sd2;
      applyStimulus("if ( ( x ) <= ( 5 ) ) begin a <= 73 ; endelse begin b <= 37 ;", 1'b0);
      checkErr("var_mismatch", 4'd2);

      // Missing semicolon: no error until the 'e' after 73.
      applyReset();
      applyStimulus("if ( x <= 5 ) begin a <= 73 ", 1'b0);
      checkOutput("nosemi_before", 32'(error_flag), 32'd0);
      applyStimulus("e", 1'b0);
      checkErr("nosemi", 4'd4);

      applyReset();
      applyStimulus("iff ( x < 5 ) begin a <= 1 ; end else begin a <= 2 ; end", 1'b0);
      checkErr("bad_kw", 4'd1);

      applyReset();
      applyStimulus("if ( x 5 ) begin a <= 1 ; end else begin a <= 2 ; end", 1'b0);
      checkErr("no_relop", 4'd5);

      applyReset();
      applyStimulus("if ( x =< 5 )", 1'b0);
      checkErr("bad_relop", 4'd5);

      applyReset();
      applyStimulus("if ( ( x <= 5 )", 1'b0);
      checkErr("unbalanced", 4'd6);

      applyReset();
      applyStimulus("if ( x < 5 ) begin ab <= 1 ;", 1'b0);
      checkErr("two_letter_var", 4'd6);

      applyReset();
      applyStimulus("if ( x", 1'b0);
      feedChar(7'h01, 1'b0);
      @(negedge clk);
      char_valid = 1'b0;
      checkErr("ctrl_char", 4'd3);

      // Reset mid-statement, then a fresh statement with negative operands.
      applyReset();
      x = -32'sd3;
      applyStimulus("if ( x > -4 ) begin", 1'b0);
      checkOutput("mid_err", 32'(error_flag), 32'd0);
      applyReset();
      applyStimulus("if ( x > -4 ) begin a <= 9 ; end else begin a <= 10 ; end", 1'b0);
      checkDone("mid_reset", 32'd9, 7'h61);

      // Compact spacing, equality, negative assigned value.
      applyReset();
      x = 32'sd3;
      applyStimulus("if(x==3)begin z<=-5;endelse begin z<=4;end", 1'b0);
      checkDone("compact_eq", 32'hFFFF_FFFB, 7'h7A);
      applyReset();
      x = 32'sd4;
      applyStimulus("if(x==3)begin z<=-5;endelse begin z<=4;end", 1'b0);
      checkDone("compact_ne", 32'd4, 7'h7A);

      // Three paren levels, != operator, literal that wraps to all ones.
      applyReset();
      x = 32'sd7;
      applyStimulus("if (((7)) != (((x)))) begin q <= 4294967295; end else begin q <= 0; end", 1'b0);
      checkDone("deep_false", 32'd0, 7'h71);
      applyReset();
      x = 32'sd1;
      applyStimulus("if (((7)) != (((x)))) begin q <= 4294967295; end else begin q <= 0; end", 1'b0);
      checkDone("deep_true", 32'hFFFF_FFFF, 7'h71);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
